// File: rtl/hci_ext_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hci_ext_rr_arbiter
// Description : Round-robin arbiter sharing the single external HCI TCDM port
//               between N_REQ initiators. A request that is not granted keeps
//               the port locked until its handshake. An in-order ID FIFO
//               routes each response back to the requester that issued it.
// Ports       : clk_i, rst_ni (async, active low), clear_i (sync clear)
//               in_*   : upstream requester side (packed per requester)
//               out_*  : downstream ext_tcdm_* side of hci_system
//               outstanding_o : ID FIFO occupancy
//               drop_o        : one-cycle pulse after a stray response
// Revision    : 1.0 - initial release
// ============================================================================
module hci_ext_rr_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BW        = 8,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic [N_REQ-1:0]                in_req_i,
    output logic [N_REQ-1:0]                in_gnt_o,
    input  logic [N_REQ*AW-1:0]             in_add_i,
    input  logic [N_REQ-1:0]                in_wen_i,
    input  logic [N_REQ*DW-1:0]             in_data_i,
    input  logic [N_REQ*(DW/BW)-1:0]        in_be_i,
    input  logic [N_REQ-1:0]                in_r_ready_i,
    output logic [DW-1:0]                   in_r_data_o,
    output logic [N_REQ-1:0]                in_r_valid_o,
    output logic                            out_req_o,
    input  logic                            out_gnt_i,
    output logic [AW-1:0]                   out_add_o,
    output logic                            out_wen_o,
    output logic [DW-1:0]                   out_data_o,
    output logic [(DW/BW)-1:0]              out_be_o,
    input  logic [DW-1:0]                   out_r_data_i,
    input  logic                            out_r_valid_i,
    output logic                            out_r_ready_o,
    output logic [$clog2(MAX_OUTST+1)-1:0]  outstanding_o,
    output logic                            drop_o
);

    localparam int unsigned c_bew = DW / BW;
    localparam int unsigned c_iw  = $clog2(N_REQ);
    localparam int unsigned c_sw  = c_iw + 1;
    localparam int unsigned c_cw  = $clog2(MAX_OUTST + 1);
    localparam int unsigned c_pw  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Arbitration state
    logic [c_iw-1:0] r_ptr;
    logic            r_lock;
    logic [c_iw-1:0] r_lock_idx;

    // ID FIFO state
    logic [c_iw-1:0] r_fifo [MAX_OUTST];
    logic [c_pw-1:0] r_wr;
    logic [c_pw-1:0] r_rd;
    logic [c_cw-1:0] r_count;
    logic            r_drop;

    logic [c_iw-1:0] w_search;
    logic            w_found;
    logic [c_sw-1:0] w_cand;
    logic [c_iw-1:0] w_sel;
    logic            w_active;
    logic            w_full;
    logic            w_empty;
    logic            w_hs;
    logic            w_pop;
    logic [c_iw-1:0] w_head;

    // First requester at or after r_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_search = '0;
        w_cand   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + c_sw'(i);
            if (w_cand >= c_sw'(N_REQ)) begin
                w_cand = w_cand - c_sw'(N_REQ);
            end
            if (!w_found && in_req_i[w_cand[c_iw-1:0]]) begin
                w_found  = 1'b1;
                w_search = w_cand[c_iw-1:0];
            end
        end
    end

    // A locked requester is held even if it withdraws its request, so the
    // downstream payload never changes between request and grant.
    assign w_sel    = r_lock ? r_lock_idx : w_search;
    assign w_active = r_lock | (|in_req_i);
    assign w_full   = (r_count == c_cw'(MAX_OUTST));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_fifo[r_rd];

    assign out_req_o = w_active & ~w_full;
    assign w_hs      = out_req_o & out_gnt_i;
    assign in_gnt_o  = w_hs ? (N_REQ'(1) << w_sel) : '0;

    always_comb begin
        out_add_o  = '0;
        out_wen_o  = 1'b0;
        out_data_o = '0;
        out_be_o   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_active && (w_sel == c_iw'(k))) begin
                out_add_o  = in_add_i[k*AW +: AW];
                out_wen_o  = in_wen_i[k];
                out_data_o = in_data_i[k*DW +: DW];
                out_be_o   = in_be_i[k*c_bew +: c_bew];
            end
        end
    end

    // With no owner on record, responses are always accepted and discarded.
    assign out_r_ready_o = w_empty ? 1'b1 : in_r_ready_i[w_head];
    assign in_r_valid_o  = (out_r_valid_i && !w_empty) ? (N_REQ'(1) << w_head) : '0;
    assign in_r_data_o   = out_r_data_i;
    assign w_pop         = out_r_valid_i & out_r_ready_o & ~w_empty;

    assign outstanding_o = r_count;
    assign drop_o        = r_drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_drop     <= 1'b0;
        end else if (clear_i) begin
            r_ptr      <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= out_r_valid_i & w_empty;

            if (w_hs) begin
                r_lock <= 1'b0;
                r_ptr  <= (w_sel == c_iw'(N_REQ - 1)) ? '0 : w_sel + c_iw'(1);
                r_wr   <= (r_wr == c_pw'(MAX_OUTST - 1)) ? '0 : r_wr + c_pw'(1);
            end else if (out_req_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_sel;
            end

            if (w_pop) begin
                r_rd <= (r_rd == c_pw'(MAX_OUTST - 1)) ? '0 : r_rd + c_pw'(1);
            end

            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ID storage needs no reset: entries are only read while the count says valid.
    always_ff @(posedge clk_i) begin
        if (w_hs && !clear_i) begin
            r_fifo[r_wr] <= w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hci_ext_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hci_ext_rr_arbiter
// Description : Self-checking bench for hci_ext_rr_arbiter. Directed scenarios
//               followed by randomized traffic, all compared each cycle
//               against a queue-based reference model of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hci_ext_rr_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 8;
    localparam int MO  = 4;
    localparam int BEW = DW / BW;
    localparam int CW  = $clog2(MO + 1);

    logic              clk;
    logic              rst_ni;
    logic              clear_i;
    logic [N-1:0]      in_req_i;
    logic [N-1:0]      in_gnt_o;
    logic [N*AW-1:0]   in_add_i;
    logic [N-1:0]      in_wen_i;
    logic [N*DW-1:0]   in_data_i;
    logic [N*BEW-1:0]  in_be_i;
    logic [N-1:0]      in_r_ready_i;
    logic [DW-1:0]     in_r_data_o;
    logic [N-1:0]      in_r_valid_o;
    logic              out_req_o;
    logic              out_gnt_i;
    logic [AW-1:0]     out_add_o;
    logic              out_wen_o;
    logic [DW-1:0]     out_data_o;
    logic [BEW-1:0]    out_be_o;
    logic [DW-1:0]     out_r_data_i;
    logic              out_r_valid_i;
    logic              out_r_ready_o;
    logic [CW-1:0]     outstanding_o;
    logic              drop_o;

    hci_ext_rr_arbiter #(
        .N_REQ(N), .AW(AW), .DW(DW), .BW(BW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
        .in_wen_i(in_wen_i), .in_data_i(in_data_i), .in_be_i(in_be_i),
        .in_r_ready_i(in_r_ready_i), .in_r_data_o(in_r_data_o),
        .in_r_valid_o(in_r_valid_o), .out_req_o(out_req_o), .out_gnt_i(out_gnt_i),
        .out_add_o(out_add_o), .out_wen_o(out_wen_o), .out_data_o(out_data_o),
        .out_be_o(out_be_o), .out_r_data_i(out_r_data_i),
        .out_r_valid_i(out_r_valid_i), .out_r_ready_o(out_r_ready_o),
        .outstanding_o(outstanding_o), .drop_o(drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: owners of outstanding transactions in issue order.
    int m_q[$];
    int m_ptr  = 0;
    bit m_lock = 0;
    int m_lidx = 0;
    bit m_drop = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr  = 0;
        m_lock = 0;
        m_lidx = 0;
        m_drop = 0;
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model,
    // then advance the model across the rising edge.
    task automatic step(input logic [N-1:0] req, input logic g, input logic v,
                        input logic [N-1:0] rr, input logic clr);
        int  sel;
        bit  found;
        bit  active;
        bit  full;
        bit  empty;
        bit  ereq;
        bit  hs;
        bit  pop;
        int  head;
        int  dmy;
        logic [N-1:0] egnt;
        logic [N-1:0] ervalid;
        logic         erready;

        @(negedge clk);
        in_req_i      = req;
        out_gnt_i     = g;
        out_r_valid_i = v;
        in_r_ready_i  = rr;
        clear_i       = clr;
        out_r_data_i  = $urandom;
        in_wen_i      = N'($urandom);
        for (int k = 0; k < N; k++) begin
            in_add_i[k*AW +: AW]   = $urandom;
            in_data_i[k*DW +: DW]  = $urandom;
            in_be_i[k*BEW +: BEW]  = BEW'($urandom);
        end
        #1;

        found = 0;
        sel   = 0;
        if (m_lock) begin
            sel = m_lidx;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[(m_ptr + i) % N]) begin
                    found = 1;
                    sel   = (m_ptr + i) % N;
                end
            end
        end
        active  = m_lock || (req != 0);
        full    = (m_q.size() == MO);
        empty   = (m_q.size() == 0);
        head    = empty ? 0 : m_q[0];
        ereq    = active && !full;
        hs      = ereq && g;
        egnt    = hs ? N'(1 << sel) : '0;
        ervalid = (v && !empty) ? N'(1 << head) : '0;
        erready = empty ? 1'b1 : rr[head];
        pop     = v && erready && !empty;

        check("out_req", 64'(out_req_o), 64'(ereq));
        check("in_gnt", 64'(in_gnt_o), 64'(egnt));
        check("out_add", 64'(out_add_o), active ? 64'(in_add_i[sel*AW +: AW]) : 64'(0));
        check("out_wen", 64'(out_wen_o), active ? 64'(in_wen_i[sel]) : 64'(0));
        check("out_data", 64'(out_data_o), active ? 64'(in_data_i[sel*DW +: DW]) : 64'(0));
        check("out_be", 64'(out_be_o), active ? 64'(in_be_i[sel*BEW +: BEW]) : 64'(0));
        check("in_r_valid", 64'(in_r_valid_o), 64'(ervalid));
        check("in_r_data", 64'(in_r_data_o), 64'(out_r_data_i));
        check("out_r_ready", 64'(out_r_ready_o), 64'(erready));
        check("outstanding", 64'(outstanding_o), 64'(m_q.size()));
        check("drop", 64'(drop_o), 64'(m_drop));

        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            m_drop = v && empty;
            if (pop) dmy = m_q.pop_front();
            if (hs) begin
                m_q.push_back(sel);
                m_ptr  = (sel + 1) % N;
                m_lock = 0;
            end else if (ereq) begin
                m_lock = 1;
                m_lidx = sel;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni        = 1'b0;
        clear_i       = 1'b0;
        in_req_i      = '0;
        out_gnt_i     = 1'b0;
        out_r_valid_i = 1'b0;
        in_r_ready_i  = '0;
        model_reset();
        #1;
        check("rst_out_req", 64'(out_req_o), 64'(0));
        check("rst_in_gnt", 64'(in_gnt_o), 64'(0));
        check("rst_in_r_valid", 64'(in_r_valid_o), 64'(0));
        check("rst_outstanding", 64'(outstanding_o), 64'(0));
        check("rst_drop", 64'(drop_o), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni        = 1'b1;
        clear_i       = 1'b0;
        in_req_i      = '0;
        in_add_i      = '0;
        in_wen_i      = '0;
        in_data_i     = '0;
        in_be_i       = '0;
        in_r_ready_i  = '0;
        out_gnt_i     = 1'b0;
        out_r_data_i  = '0;
        out_r_valid_i = 1'b0;
        #2;
        do_reset();

        // Single read: grant, then response next cycle.
        step(4'b0001, 1, 0, 4'b1111, 0);
        step(4'b0000, 0, 1, 4'b1111, 0);
        step(4'b0000, 0, 0, 4'b1111, 0);

        // All requesting with immediate responses: round-robin rotation.
        for (int i = 0; i < 6; i++) step(4'b1111, 1, (i != 0), 4'b1111, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 0, 1, 4'b1111, 0);

        // Lock: requester 1 waits three cycles, requester 2 joins meanwhile.
        do_reset();
        step(4'b0010, 0, 0, 4'b1111, 0);
        step(4'b0110, 0, 0, 4'b1111, 0);
        step(4'b0110, 0, 0, 4'b1111, 0);
        step(4'b0110, 1, 0, 4'b1111, 0);
        step(4'b0100, 1, 0, 4'b1111, 0);

        // Fill the ID FIFO, stall, pop once, then forward again.
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0001, 1, 0, 4'b1111, 0);
        step(4'b0001, 1, 1, 4'b1111, 0);
        step(4'b0001, 1, 0, 4'b1111, 0);

        // Head owner not ready: response held back.
        step(4'b0000, 0, 1, 4'b1110, 0);
        step(4'b0000, 0, 1, 4'b1110, 0);
        step(4'b0000, 0, 1, 4'b1111, 0);

        // Reset with transactions outstanding, then a late response.
        do_reset();
        step(4'b0011, 1, 0, 4'b1111, 0);
        step(4'b0011, 1, 0, 4'b1111, 0);
        do_reset();
        step(4'b0000, 0, 1, 4'b1111, 0);
        step(4'b0000, 0, 0, 4'b1111, 0);
        step(4'b0000, 0, 0, 4'b1111, 0);

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 250) == 0) begin
                do_reset();
            end else begin
                step(N'($urandom), (($urandom % 4) != 0), (($urandom % 2) == 0),
                     N'($urandom | $urandom), (($urandom % 100) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
